// File: rtl/vend_pkg.sv
// Shared types and constants for the vending sequencer.
// Coin denominations and the controller state encoding live here so the top and tests agree.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } vend_state_t;

    localparam int unsigned COIN5_VAL  = 5;
    localparam int unsigned COIN10_VAL = 10;

endpackage

// File: rtl/vend_timeout_ctr.sv
// Inactivity down-counter: reload on activity, count while enabled, flag when exhausted.
// Saturates at zero so an expiry that loses a priority race stays visible next cycle.
module vend_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
    // Loaded with TIMEOUT_CYC-1 so expiry is seen exactly TIMEOUT_CYC cycles after the reload edge.
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (reload) begin
            count <= LOAD_VAL;
        end else if (en && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/vend_sequencer.sv
// Multi-product vending controller: credit accumulation, price check, dispense handshake,
// coin-by-coin change return and refund on cancel or inactivity. All outputs are registered.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int unsigned NPROD       = 4,
    parameter int unsigned CREDIT_W    = 8,
    parameter int unsigned MAX_CREDIT  = 100,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        coin5,
    input  logic                        coin10,
    input  logic                        cancel,
    input  logic                        sel_valid,
    input  logic [$clog2(NPROD)-1:0]    sel_id,
    input  logic [NPROD*CREDIT_W-1:0]   prices,
    output logic                        disp_req,
    output logic [$clog2(NPROD)-1:0]    disp_id,
    input  logic                        disp_done,
    output logic                        chg_req,
    output logic                        chg_coin,
    input  logic                        chg_ack,
    output logic                        coin_reject,
    output logic                        sel_denied,
    output logic [CREDIT_W-1:0]         credit,
    output logic                        busy
);

    localparam int unsigned IDW = $clog2(NPROD);
    localparam logic [CREDIT_W:0]   MAX_EXT = (CREDIT_W + 1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] C5      = CREDIT_W'(COIN5_VAL);
    localparam logic [CREDIT_W-1:0] C10     = CREDIT_W'(COIN10_VAL);

    vend_state_t          state_q, state_d;
    logic [CREDIT_W-1:0]  credit_d;
    logic [IDW-1:0]       disp_id_d;
    logic                 chg_req_d, chg_coin_d, coin_reject_d, sel_denied_d;
    logic                 disp_req_d, busy_d;

    logic                 tmo_reload, tmo_en, tmo_expired;
    logic [CREDIT_W-1:0]  price_sel;
    logic [CREDIT_W-1:0]  coin_val;
    logic                 coin_any;
    logic [CREDIT_W:0]    credit_sum;
    logic                 coin_fits;
    logic [CREDIT_W-1:0]  credit_after_chg;
    vend_state_t          refund_state;
    logic                 refund_req, refund_coin;

    vend_timeout_ctr #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .reload  (tmo_reload),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    always_comb begin
        price_sel = '0;
        for (int unsigned i = 0; i < NPROD; i++) begin
            if (sel_id == IDW'(i)) begin
                price_sel = prices[i*CREDIT_W +: CREDIT_W];
            end
        end
    end

    // coin10 wins a simultaneous insertion; the coin5 is always bounced in that case.
    always_comb begin
        coin_any = coin5 | coin10;
        coin_val = '0;
        if (coin10) begin
            coin_val = C10;
        end else if (coin5) begin
            coin_val = C5;
        end
        credit_sum       = {1'b0, credit} + {1'b0, coin_val};
        coin_fits        = (credit_sum <= MAX_EXT);
        credit_after_chg = credit - (chg_coin ? C10 : C5);
        refund_state     = (credit == '0) ? ST_IDLE : ST_CHANGE;
        refund_req       = (credit != '0);
        refund_coin      = (credit >= C10);
    end

    always_comb begin
        state_d       = state_q;
        credit_d      = credit;
        disp_id_d     = disp_id;
        chg_req_d     = chg_req;
        chg_coin_d    = chg_coin;
        coin_reject_d = coin5 & coin10;
        sel_denied_d  = 1'b0;
        tmo_reload    = 1'b0;
        tmo_en        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                sel_denied_d = sel_valid;
                if (coin_any) begin
                    if (coin_fits) begin
                        credit_d   = credit_sum[CREDIT_W-1:0];
                        state_d    = ST_CREDIT;
                        tmo_reload = 1'b1;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end

            ST_CREDIT: begin
                tmo_en = 1'b1;
                if (cancel) begin
                    coin_reject_d = coin_reject_d | coin_any;
                    state_d       = refund_state;
                    chg_req_d     = refund_req;
                    chg_coin_d    = refund_coin;
                end else if (sel_valid) begin
                    // Selection is judged on the pre-coin credit; a same-cycle coin bounces.
                    coin_reject_d = coin_reject_d | coin_any;
                    if (credit >= price_sel) begin
                        credit_d  = credit - price_sel;
                        disp_id_d = sel_id;
                        state_d   = ST_VEND;
                    end else begin
                        sel_denied_d = 1'b1;
                    end
                end else if (tmo_expired) begin
                    coin_reject_d = coin_reject_d | coin_any;
                    state_d       = refund_state;
                    chg_req_d     = refund_req;
                    chg_coin_d    = refund_coin;
                end else if (coin_any) begin
                    if (coin_fits) begin
                        credit_d   = credit_sum[CREDIT_W-1:0];
                        tmo_reload = 1'b1;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end

            ST_VEND: begin
                coin_reject_d = coin_reject_d | coin_any;
                if (disp_done) begin
                    state_d    = refund_state;
                    chg_req_d  = refund_req;
                    chg_coin_d = refund_coin;
                end
            end

            ST_CHANGE: begin
                coin_reject_d = coin_reject_d | coin_any;
                if (chg_req) begin
                    if (chg_ack) begin
                        credit_d  = credit_after_chg;
                        chg_req_d = 1'b0;
                        if (credit_after_chg == '0) begin
                            state_d = ST_IDLE;
                        end
                    end
                end else if (credit == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    chg_req_d  = 1'b1;
                    chg_coin_d = (credit >= C10);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        disp_req_d = (state_d == ST_VEND);
        busy_d     = (state_d == ST_VEND) || (state_d == ST_CHANGE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            credit      <= '0;
            disp_id     <= '0;
            disp_req    <= 1'b0;
            chg_req     <= 1'b0;
            chg_coin    <= 1'b0;
            coin_reject <= 1'b0;
            sel_denied  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            credit      <= credit_d;
            disp_id     <= disp_id_d;
            disp_req    <= disp_req_d;
            chg_req     <= chg_req_d;
            chg_coin    <= chg_coin_d;
            coin_reject <= coin_reject_d;
            sel_denied  <= sel_denied_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer: a vector table for the single-cycle behaviour plus
// hand-written sequences for the inactivity refund and a reset during change return.
module tb_vend_sequencer;

    localparam int unsigned NPROD       = 4;
    localparam int unsigned CREDIT_W    = 8;
    localparam int unsigned MAX_CREDIT  = 100;
    localparam int unsigned TIMEOUT_CYC = 20;

    logic                      clk;
    logic                      rst;
    logic                      coin5, coin10, cancel, sel_valid;
    logic [1:0]                sel_id;
    logic [NPROD*CREDIT_W-1:0] prices;
    logic                      disp_req;
    logic [1:0]                disp_id;
    logic                      disp_done;
    logic                      chg_req, chg_coin, chg_ack;
    logic                      coin_reject, sel_denied, busy;
    logic [CREDIT_W-1:0]       credit;

    int n_tests;
    int n_fail;

    vend_sequencer #(
        .NPROD      (NPROD),
        .CREDIT_W   (CREDIT_W),
        .MAX_CREDIT (MAX_CREDIT),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .coin5      (coin5),
        .coin10     (coin10),
        .cancel     (cancel),
        .sel_valid  (sel_valid),
        .sel_id     (sel_id),
        .prices     (prices),
        .disp_req   (disp_req),
        .disp_id    (disp_id),
        .disp_done  (disp_done),
        .chg_req    (chg_req),
        .chg_coin   (chg_coin),
        .chg_ack    (chg_ack),
        .coin_reject(coin_reject),
        .sel_denied (sel_denied),
        .credit     (credit),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       c5, c10, can, sel;
        logic [1:0] id;
        logic       done, ack;
        logic [7:0] credit;
        logic       dreq;
        logic [1:0] did;
        logic       creq, ccoin, rej, den, busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic c5, c10, can, sel, input logic [1:0] id,
                               input logic done, ack, input int cr, input logic dreq,
                               input logic [1:0] did, input logic creq, ccoin, rej, den, bsy);
        vec_t r;
        r.c5 = c5; r.c10 = c10; r.can = can; r.sel = sel; r.id = id;
        r.done = done; r.ack = ack; r.credit = 8'(cr); r.dreq = dreq; r.did = did;
        r.creq = creq; r.ccoin = ccoin; r.rej = rej; r.den = den; r.busy = bsy;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        coin5 = 0; coin10 = 0; cancel = 0; sel_valid = 0; sel_id = 0;
        disp_done = 0; chg_ack = 0;
    endtask

    task automatic chk_all_zero(input string name, input int idx);
        chk({name, ".credit"}, idx, 32'(credit), 0);
        chk({name, ".disp_req"}, idx, 32'(disp_req), 0);
        chk({name, ".disp_id"}, idx, 32'(disp_id), 0);
        chk({name, ".chg_req"}, idx, 32'(chg_req), 0);
        chk({name, ".chg_coin"}, idx, 32'(chg_coin), 0);
        chk({name, ".coin_reject"}, idx, 32'(coin_reject), 0);
        chk({name, ".sel_denied"}, idx, 32'(sel_denied), 0);
        chk({name, ".busy"}, idx, 32'(busy), 0);
    endtask

    initial begin
        int edges;
        bit seen;
        n_tests = 0;
        n_fail  = 0;
        // id0=10, id1=15, id2=0, id3=95
        prices = {8'd95, 8'd0, 8'd15, 8'd10};
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset", 0);
        rst = 1'b0;

        //        c5 c10 can sel id dn ak  cr  drq did crq cc rej den bsy
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 0,  10, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0,  15, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 1, 0, 0,   0, 1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 0,  10, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 0,  20, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 0,  30, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 1, 0, 0,  15, 1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 0,  15, 1, 1, 0, 0, 1, 0, 1));
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 0,  15, 1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 0,  15, 0, 1, 1, 1, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0,  15, 0, 1, 1, 1, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1,   5, 0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1,   5, 0, 1, 1, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 0, 1, 1,   0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0,   0, 0, 1, 0, 0, 0, 1, 0));
        for (int k = 1; k <= 9; k++)
            vecs.push_back(v(0, 1, 0, 0, 0, 0, 0, 10*k, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0,  95, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 0,  95, 0, 1, 0, 0, 1, 0, 0));
        vecs.push_back(v(1, 1, 0, 0, 0, 0, 0,  95, 0, 1, 0, 0, 1, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 100, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 100, 0, 1, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 3, 0, 0,   5, 1, 3, 0, 0, 1, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 0,   5, 0, 3, 1, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1,   0, 0, 3, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0,   5, 0, 3, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 2, 0, 0,   5, 1, 2, 0, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 0,   5, 0, 2, 1, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1,   0, 0, 2, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 0,  10, 0, 2, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 1, 0, 0, 0, 0,  10, 0, 2, 1, 1, 1, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1,   0, 0, 2, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0,   5, 0, 2, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 0,   5, 0, 2, 0, 0, 0, 1, 0));
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 0,   5, 0, 2, 1, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1,   0, 0, 2, 0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            coin5 = vecs[i].c5; coin10 = vecs[i].c10; cancel = vecs[i].can;
            sel_valid = vecs[i].sel; sel_id = vecs[i].id;
            disp_done = vecs[i].done; chg_ack = vecs[i].ack;
            tick();
            clear_inputs();
            chk("credit", i, 32'(credit), 32'(vecs[i].credit));
            chk("disp_req", i, 32'(disp_req), 32'(vecs[i].dreq));
            chk("disp_id", i, 32'(disp_id), 32'(vecs[i].did));
            chk("chg_req", i, 32'(chg_req), 32'(vecs[i].creq));
            if (vecs[i].creq)
                chk("chg_coin", i, 32'(chg_coin), 32'(vecs[i].ccoin));
            chk("coin_reject", i, 32'(coin_reject), 32'(vecs[i].rej));
            chk("sel_denied", i, 32'(sel_denied), 32'(vecs[i].den));
            chk("busy", i, 32'(busy), 32'(vecs[i].busy));
        end

        // Inactivity refund: coin, refused selection, then wait for automatic change return.
        coin5 = 1; tick(); clear_inputs();
        chk("tmo.credit", 0, 32'(credit), 5);
        sel_valid = 1; sel_id = 1; tick(); clear_inputs();
        chk("tmo.sel_denied", 0, 32'(sel_denied), 1);
        chk("tmo.credit_kept", 0, 32'(credit), 5);
        edges = 1;
        seen = 0;
        while (!seen && edges < TIMEOUT_CYC + 5) begin
            tick();
            edges++;
            if (chg_req) seen = 1;
        end
        chk("tmo.seen", 0, 32'(seen), 1);
        chk("tmo.edges_ge", 0, 32'(edges >= TIMEOUT_CYC), 1);
        chk("tmo.edges_le", 0, 32'(edges <= TIMEOUT_CYC + 1), 1);
        chk("tmo.chg_coin", 0, 32'(chg_coin), 0);
        chk("tmo.busy", 0, 32'(busy), 1);
        chg_ack = 1; tick(); clear_inputs();
        chk("tmo.credit_end", 0, 32'(credit), 0);
        chk("tmo.chg_req_end", 0, 32'(chg_req), 0);
        chk("tmo.busy_end", 0, 32'(busy), 0);

        // Reset while a change coin is being requested.
        coin10 = 1; tick(); clear_inputs();
        cancel = 1; tick(); clear_inputs();
        chk("rst.pre_chg_req", 0, 32'(chg_req), 1);
        #2 rst = 1'b1;
        #1 chk_all_zero("rst.async", 0);
        tick();
        chk_all_zero("rst.held", 0);
        rst = 1'b0;
        chg_ack = 1; tick(); clear_inputs();
        chk_all_zero("rst.after", 0);
        coin5 = 1; tick(); clear_inputs();
        chk("rst.idle_coin", 0, 32'(credit), 5);
        chk("rst.idle_busy", 0, 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
